// File: rtl/mdu_defs.sv
// Shared definitions for the multiply/divide unit: operation codes and FSM states.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_NOP   = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step on unsigned magnitudes; the caller iterates it WIDTH times.
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // quo doubles as the dividend shift register: its MSB feeds the remainder
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    rem_sh   = {rem, quo[WIDTH-1]};
    diff     = rem_sh - {1'b0, divisor};
    fits     = (rem_sh >= {1'b0, divisor});
    rem_next = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy interlocks HI/LO readers in ID.
module mdu_hilo
  import mdu_defs::*;
#(
  parameter int MUL_LAT = 2,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 8) ? $clog2(WIDTH) : 3;

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] rem;
  logic             mul_signed;
  logic             q_neg;
  logic             r_neg;

  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   rem_nx;
  logic [WIDTH-1:0]   quo_nx;
  logic               accept;
  logic               div_signed;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
    return cond_neg(v, sgn & v[WIDTH-1]);
  endfunction

  // Sign/zero extension to 2*WIDTH makes one truncated multiply serve both MULT and MULTU
  always_comb begin
    ext_a   = mul_signed ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
    ext_b   = mul_signed ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
    product = ext_a * ext_b;
  end

  assign accept     = start && !flush && (state == IDLE);
  assign div_signed = (op == MDU_DIV);

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem      (rem),
    .quo      (op_a),
    .divisor  (op_b),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cnt        <= '0;
      op_a       <= '0;
      op_b       <= '0;
      rem        <= '0;
      mul_signed <= 1'b0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            case (op)
              MDU_MTHI: hi <= rs_data;
              MDU_MTLO: lo <= rs_data;
              MDU_MULT, MDU_MULTU: begin
                op_a       <= rs_data;
                op_b       <= rt_data;
                mul_signed <= (op == MDU_MULT);
                cnt        <= CNT_W'(MUL_LAT - 1);
                state      <= MUL;
                busy       <= 1'b1;
              end
              MDU_DIV, MDU_DIVU: begin
                if (rt_data == '0) begin
                  hi <= rs_data;
                  lo <= '1;
                end else begin
                  op_a  <= magnitude(rs_data, div_signed);
                  op_b  <= magnitude(rt_data, div_signed);
                  rem   <= '0;
                  q_neg <= div_signed & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
                  r_neg <= div_signed & rs_data[WIDTH-1];
                  cnt   <= CNT_W'(WIDTH - 1);
                  state <= DIV;
                  busy  <= 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
        MUL: begin
          if (cnt == '0) begin
            {hi, lo} <= product;
            state    <= IDLE;
            busy     <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV: begin
          rem  <= rem_nx;
          op_a <= quo_nx;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: begin
          hi    <= cond_neg(rem, r_neg);
          lo    <= cond_neg(op_a, q_neg);
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: directed vectors, monitor checks hi/lo and busy length per result.
module tb_mdu_hilo;
  import mdu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  mdu_hilo #(.MUL_LAT(2), .WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op      (op),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .flush   (flush),
    .busy    (busy),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          blen;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] cur_hi = '0;
  logic [31:0] cur_lo = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor: a result is due one cycle after an instant op is accepted, or when busy falls
  logic prev_busy = 1'b0;
  logic pend = 1'b0;
  int   bcnt = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_busy = 1'b0;
      pend      = 1'b0;
      bcnt      = 0;
    end else begin
      if (pend || (prev_busy && !busy)) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_result: hi=%h lo=%h with empty scoreboard", hi, lo);
        end else begin
          e = sb.pop_front();
          check("hi", hi, e.hi);
          check("lo", lo, e.lo);
          check("busy_len", 32'(bcnt), 32'(e.blen));
          check("busy_at_result", {31'd0, busy}, 32'd0);
        end
        bcnt = 0;
      end
      pend = start && !flush && !busy &&
             (op == MDU_MTHI || op == MDU_MTLO ||
              ((op == MDU_DIV || op == MDU_DIVU) && rt_data == 32'd0));
      if (busy) bcnt++;
      prev_busy = busy;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic expect_push(input logic [31:0] h, input logic [31:0] l, input int blen);
    exp_t e;
    e.hi = h; e.lo = l; e.blen = blen;
    sb.push_back(e);
    cur_hi = h; cur_lo = l;
  endtask

  task automatic drain(input string name);
    int k;
    for (k = 0; k < 100 && sb.size() != 0; k++) step();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: %0d results outstanding, expected 0", name, sb.size());
      sb.delete();
    end
    step();
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                     input int blen);
    expect_push(h, l, blen);
    issue(o, a, b);
    drain(name);
  endtask

  initial begin
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    rst_n = 1'b1;
    step();

    run("mult",  MDU_MULT,  32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 32'hFFFFFFFA, 2);
    run("multu", MDU_MULTU, 32'hFFFFFFFE, 32'h3, 32'h00000002, 32'hFFFFFFFA, 2);
    run("div_neg",  MDU_DIV,  32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);
    run("divu",     MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 33);
    run("div_negd", MDU_DIV,  32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 33);
    run("div_both", MDU_DIV,  32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 33);
    run("div_ovf",  MDU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 33);
    run("divu_big", MDU_DIVU, 32'hFFFFFFFF, 32'h10, 32'h0000000F, 32'h0FFFFFFF, 33);
    run("divu_z",   MDU_DIVU, 32'h12345678, 32'd0, 32'h12345678, 32'hFFFFFFFF, 0);
    run("div_z",    MDU_DIV,  32'h87654321, 32'd0, 32'h87654321, 32'hFFFFFFFF, 0);

    // MTLO dropped when flushed in the same cycle
    flush = 1'b1;
    issue(MDU_MTLO, 32'hA5A5A5A5, 32'd0);
    flush = 1'b0;
    step();
    check("flush_mtlo_lo", lo, cur_lo);
    check("flush_mtlo_busy", {31'd0, busy}, 32'd0);
    run("mtlo", MDU_MTLO, 32'hA5A5A5A5, 32'd0, cur_hi, 32'hA5A5A5A5, 0);
    run("mthi", MDU_MTHI, 32'hDEADBEEF, 32'd0, 32'hDEADBEEF, 32'hA5A5A5A5, 0);

    // Undefined op and NOP leave everything alone
    issue(3'd7, 32'h11111111, 32'h2);
    issue(MDU_NOP, 32'h22222222, 32'h2);
    step();
    check("undef_busy", {31'd0, busy}, 32'd0);
    check("undef_hi", hi, 32'hDEADBEEF);
    check("undef_lo", lo, 32'hA5A5A5A5);

    // Flush plus MTHI during a DIV are ignored; DIV completes
    expect_push(32'd2, 32'd14, 33);
    issue(MDU_DIV, 32'd100, 32'd7);
    repeat (4) step();
    flush = 1'b1;
    issue(MDU_MTHI, 32'hCAFEF00D, 32'd0);
    flush = 1'b0;
    drain("div_flush");

    // Async reset in the middle of a DIV
    expect_push(32'd0, 32'd0, 33);
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) step();
    check("mid_div_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    sb.delete();
    cur_hi = '0; cur_lo = '0;
    step();
    step();
    rst_n = 1'b1;
    step();
    run("post_rst_mult", MDU_MULT, 32'd3, 32'd4, 32'd0, 32'd12, 2);
    run("post_rst_divu", MDU_DIVU, 32'd1000, 32'd3, 32'd1, 32'd333, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
